// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch unit's memory, decode-stage and redirect signals.
// The master side belongs to the fetch unit; the slave side belongs to its environment.
interface instruction_fetch_unit_if;
  logic [63:0] Inst_Addr;
  logic [31:0] Instruction;
  logic        id_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output Inst_Addr,
    input  Instruction,
    input  id_ready,
    input  branch_taken,
    input  branch_target,
    output if_id_valid,
    output if_id_pc,
    output if_id_instruction,
    output halted,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  Inst_Addr,
    output Instruction,
    output id_ready,
    output branch_taken,
    output branch_target,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_instruction,
    input  halted,
    input  misalign_err,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch: PC register, IF/ID pipeline register, redirect
// handling and a FETCH/HALT controller entered by a zero word or a misaligned redirect.
module instruction_fetch_unit (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic stall;
  logic target_misaligned;

  assign stall             = valid_q & ~bus.id_ready;
  assign target_misaligned = (bus.branch_target[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    misalign_d   = misalign_q;
    count_d      = count_q;

    unique case (state_q)
      ST_FETCH: begin
        // A redirect wins over both stall and capture; the held word is flushed.
        if (bus.branch_taken) begin
          valid_d = 1'b0;
          if (target_misaligned) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d = bus.branch_target;
          end
        end else if (!stall) begin
          if (bus.Instruction == HALT_WORD) begin
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            ifid_instr_d = bus.Instruction;
            ifid_pc_d    = pc_q;
            valid_d      = 1'b1;
            pc_d         = pc_q + 64'd4;
            count_d      = (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        // Drain any word still held, but never fetch or redirect again.
        if (valid_q && bus.id_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= 64'd0;
      valid_q      <= 1'b0;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= 32'd0;
      misalign_q   <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
    end
  end

  assign bus.Inst_Addr         = pc_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.if_id_pc          = ifid_pc_q;
  assign bus.if_id_instruction = ifid_instr_q;
  assign bus.halted            = (state_q == ST_HALT);
  assign bus.misalign_err      = misalign_q;
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural fetch model is checked
// every cycle, and literal expectations pin the key scenarios.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: 64 words at addresses 0..255; elsewhere a non-zero pattern.
  logic [31:0] mem [64];

  assign bus.Instruction = (bus.Inst_Addr < 64'd256) ? mem[bus.Inst_Addr[7:2]]
                                                      : {bus.Inst_Addr[31:2], 2'b01};

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    logic [31:0] w;
    if (a < 64'd256) w = mem[a[7:2]];
    else             w = {a[31:2], 2'b01};
    return w;
  endfunction

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the decode stage should observe after each edge.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt, m_word;
  logic        m_valid, m_halt, m_mis, m_stall;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'd0; m_ifpc = 64'd0; m_instr = 32'd0; m_cnt = 32'd0;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    end else if (!m_halt) begin
      m_stall = m_valid && !bus.id_ready;
      if (bus.branch_taken) begin
        m_valid = 1'b0;
        if (bus.branch_target[1:0] != 2'b00) begin
          m_mis = 1'b1; m_halt = 1'b1;
        end else begin
          m_pc = bus.branch_target;
        end
      end else if (!m_stall) begin
        m_word = mem_rd(m_pc);
        if (m_word == 32'd0) begin
          m_valid = 1'b0; m_halt = 1'b1;
        end else begin
          m_ifpc = m_pc; m_instr = m_word; m_valid = 1'b1;
          m_pc = m_pc + 64'd4;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
      end
    end else if (bus.id_ready) begin
      m_valid = 1'b0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model:Inst_Addr", bus.Inst_Addr, m_pc);
      chk("model:if_id_valid", 64'(bus.if_id_valid), 64'(m_valid));
      chk("model:halted", 64'(bus.halted), 64'(m_halt));
      chk("model:misalign_err", 64'(bus.misalign_err), 64'(m_mis));
      chk("model:fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
      if (m_valid) begin
        chk("model:if_id_pc", bus.if_id_pc, m_ifpc);
        chk("model:if_id_instruction", 64'(bus.if_id_instruction), 64'(m_instr));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) + 32'd1;
  endtask

  task automatic do_reset();
    bus.branch_taken = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    fill_mem();
    bus.id_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 64'd0;
    cyc(2);
    cmp_en = 1'b1;

    // Reset state and sequential fetch
    do_reset();
    chk("rst:Inst_Addr", bus.Inst_Addr, 64'd0);
    chk("rst:if_id_valid", 64'(bus.if_id_valid), 64'd0);
    chk("rst:fetch_count", 64'(bus.fetch_count), 64'd0);
    chk("rst:if_id_pc", bus.if_id_pc, 64'd0);
    bus.id_ready = 1'b1;
    cyc(1);
    chk("seq:Inst_Addr1", bus.Inst_Addr, 64'd4);
    chk("seq:if_id_pc1", bus.if_id_pc, 64'd0);
    chk("seq:instr1", 64'(bus.if_id_instruction), 64'h1000_0001);
    cyc(1);
    chk("seq:Inst_Addr2", bus.Inst_Addr, 64'd8);
    chk("seq:if_id_pc2", bus.if_id_pc, 64'd4);
    cyc(1);
    chk("seq:Inst_Addr3", bus.Inst_Addr, 64'd12);
    chk("seq:if_id_pc3", bus.if_id_pc, 64'd8);
    chk("seq:fetch_count", 64'(bus.fetch_count), 64'd3);
    $display("txn sequential fetch: Inst_Addr=%h count=%0d", bus.Inst_Addr, bus.fetch_count);

    // Stall for 3 cycles after the first capture
    do_reset();
    bus.id_ready = 1'b1;
    cyc(1);
    bus.id_ready = 1'b0;
    cyc(3);
    chk("stall:Inst_Addr", bus.Inst_Addr, 64'd4);
    chk("stall:if_id_pc", bus.if_id_pc, 64'd0);
    chk("stall:fetch_count", 64'(bus.fetch_count), 64'd1);
    chk("stall:valid", 64'(bus.if_id_valid), 64'd1);
    bus.id_ready = 1'b1;
    cyc(1);
    chk("resume:if_id_pc", bus.if_id_pc, 64'd4);
    chk("resume:fetch_count", 64'(bus.fetch_count), 64'd2);
    $display("txn stall/resume: if_id_pc=%h count=%0d", bus.if_id_pc, bus.fetch_count);

    // Redirect during a stall
    do_reset();
    bus.id_ready = 1'b1;
    cyc(1);
    bus.id_ready = 1'b0;
    cyc(1);
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h40;
    cyc(1);
    bus.branch_taken = 1'b0;
    chk("redir:Inst_Addr", bus.Inst_Addr, 64'h40);
    chk("redir:valid", 64'(bus.if_id_valid), 64'd0);
    chk("redir:fetch_count", 64'(bus.fetch_count), 64'd1);
    cyc(1);
    chk("redir:if_id_pc", bus.if_id_pc, 64'h40);
    chk("redir:valid2", 64'(bus.if_id_valid), 64'd1);
    chk("redir:fetch_count2", 64'(bus.fetch_count), 64'd2);
    $display("txn redirect: if_id_pc=%h", bus.if_id_pc);

    // Misaligned redirect from PC=0x44
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h42;
    cyc(1);
    bus.branch_taken = 1'b0;
    chk("mis:misalign_err", 64'(bus.misalign_err), 64'd1);
    chk("mis:halted", 64'(bus.halted), 64'd1);
    chk("mis:Inst_Addr", bus.Inst_Addr, 64'h44);
    cyc(3);
    chk("mis:fetch_count", 64'(bus.fetch_count), 64'd2);
    $display("txn misaligned redirect: halted=%0b misalign=%0b", bus.halted, bus.misalign_err);

    // Halt marker at address 8, then an ignored redirect
    do_reset();
    mem[2] = 32'd0;
    bus.id_ready = 1'b1;
    cyc(3);
    chk("hm:halted", 64'(bus.halted), 64'd1);
    chk("hm:Inst_Addr", bus.Inst_Addr, 64'd8);
    chk("hm:fetch_count", 64'(bus.fetch_count), 64'd2);
    chk("hm:valid", 64'(bus.if_id_valid), 64'd0);
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h80;
    cyc(1);
    bus.branch_taken = 1'b0;
    chk("hm:ignore_branch", bus.Inst_Addr, 64'd8);
    cyc(2);
    $display("txn halt marker: Inst_Addr=%h count=%0d", bus.Inst_Addr, bus.fetch_count);
    fill_mem();

    // Halt at PC=0x40, then reset
    do_reset();
    mem[16] = 32'd0;
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h40;
    cyc(1);
    bus.branch_taken = 1'b0;
    cyc(1);
    chk("rh:halted", 64'(bus.halted), 64'd1);
    chk("rh:Inst_Addr", bus.Inst_Addr, 64'h40);
    do_reset();
    chk("rh:halted0", 64'(bus.halted), 64'd0);
    chk("rh:misalign0", 64'(bus.misalign_err), 64'd0);
    chk("rh:count0", 64'(bus.fetch_count), 64'd0);
    chk("rh:Inst_Addr0", bus.Inst_Addr, 64'd0);
    chk("rh:valid0", 64'(bus.if_id_valid), 64'd0);
    $display("txn reset from halt: Inst_Addr=%h halted=%0b", bus.Inst_Addr, bus.halted);
    fill_mem();

    // PC wraps modulo 2^64
    do_reset();
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
    cyc(1);
    bus.branch_taken = 1'b0;
    cyc(2);
    chk("wrap:Inst_Addr", bus.Inst_Addr, 64'd0);
    chk("wrap:if_id_pc", bus.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap:halted", 64'(bus.halted), 64'd0);
    chk("wrap:misalign", 64'(bus.misalign_err), 64'd0);
    $display("txn pc wrap: Inst_Addr=%h", bus.Inst_Addr);

    // Irregular ready pattern, checked by the model, then reset asserted mid-stall
    for (int i = 0; i < 16; i++) begin
      bus.id_ready = ((16'b1011_0010_1110_0101 >> i) & 16'd1) != 16'd0;
      cyc(1);
    end
    bus.id_ready = 1'b0;
    cyc(1);
    do_reset();
    chk("rs:Inst_Addr", bus.Inst_Addr, 64'd0);
    chk("rs:valid", 64'(bus.if_id_valid), 64'd0);
    $display("txn ready pattern + mid-stall reset: count=%0d", bus.fetch_count);
    bus.id_ready = 1'b1;
    cyc(4);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
